// File: rtl/io_unit_pkg.sv
// Shared definitions for the board-side I/O units: FSM encoding, default widths, button status.
package io_unit_pkg;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_SWITCH_WIDTH    = 11;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t ARMED   = 2'd1;
  localparam state_t CAPTURE = 2'd2;
  localparam state_t RELEASE = 2'd3;

  typedef struct packed {
    logic pressed;     // debounced level, 1 = held down
    logic press_edge;  // one-cycle pulse on released->pressed
  } btn_st_t;
endpackage

// File: rtl/input_debouncer.sv
// ENTER pushbutton (active-low) synchronizer and debouncer; reports debounced level and press pulse.
module input_debouncer
  import io_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_enter_n,
  output btn_st_t o_btn
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_pressed;
  logic          r_edge;
  logic          w_diff;
  logic          w_flip;

  assign w_diff = (~r_sync[1]) != r_pressed;
  assign w_flip = w_diff && (r_cnt == LAST);

  // Synchronizer comes out of reset in the released state so a held button looks like a new press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_enter_n};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_pressed <= 1'b0;
      r_edge    <= 1'b0;
    end else begin
      r_edge <= w_flip & ~r_pressed;
      if (!w_diff || w_flip) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
      if (w_flip) r_pressed <= ~r_pressed;
    end
  end

  assign o_btn = '{pressed: r_pressed, press_edge: r_edge};
endmodule

// File: rtl/input_unit.sv
// Input Data source: stalls the processor until a debounced ENTER press, then presents the switches.
// Define INPUT_SIGN_EXT_EN to sign-extend the switch word; default is zero extension.
module input_unit
  import io_unit_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int SWITCH_WIDTH    = DEF_SWITCH_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SWITCH_WIDTH-1:0] i_switches,
  input  logic                    i_enter,
  input  logic                    i_req,
  output logic [DATA_WIDTH-1:0]   o_odata,
  output logic                    o_valid,
  output logic                    o_waiting
);
  logic [1:0][SWITCH_WIDTH-1:0] r_sw_sync;
  logic [DATA_WIDTH-1:0]        r_odata;
  logic [DATA_WIDTH-1:0]        w_ext;
  state_t                       r_state;
  state_t                       w_next;
  btn_st_t                      w_btn;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_enter_n (i_enter),
    .o_btn     (w_btn)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sw_sync <= '0;
    else          r_sw_sync <= {r_sw_sync[0], i_switches};
  end

`ifdef INPUT_SIGN_EXT_EN
  assign w_ext = DATA_WIDTH'($signed(r_sw_sync[1]));
`else
  assign w_ext = DATA_WIDTH'(r_sw_sync[1]);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Dropping REQ wins over a coincident press; RELEASE waits out the press that was just consumed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_req) w_next = ARMED;
      ARMED:   if (!i_req) w_next = IDLE;
               else if (w_btn.press_edge) w_next = CAPTURE;
      CAPTURE: w_next = RELEASE;
      RELEASE: if (!w_btn.pressed) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Hold register keeps the word captured during the CAPTURE cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 r_odata <= '0;
    else if (r_state == CAPTURE)  r_odata <= w_ext;
  end

  always_comb begin
    o_valid   = (r_state == CAPTURE);
    o_waiting = (r_state == ARMED);
    o_odata   = (r_state == CAPTURE) ? w_ext : r_odata;
  end
endmodule
